// File: rtl/module_mc_controller_pkg.sv
// Shared types and encodings for the multicycle control unit: state enum,
// opcodes, datapath mux encodings and the immediate-format decoder.
package pkg_mc_ctrl;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_f(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/module_mc_controller_alu_decoder.sv
// ALU operation decoder: maps the FSM's ALUOp plus instruction fields to the
// ALU control code.
module module_alu_decoder
  import pkg_mc_ctrl::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type carries a sub; addi with bit 30 set is still an add.
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/module_mc_controller.sv
// Multicycle RV32I-subset control unit: Moore FSM sequencing each instruction
// plus datapath mux selects and write strobes.
module module_mc_controller
  import pkg_mc_ctrl::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_control_o,
  output logic [1:0] imm_src_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_e  state_q, state_d;
  alu_op_e alu_op;
  logic    pc_update, branch, mem_write, ir_write, reg_write;
  logic    op_legal;

  assign op_legal = (op_i == OP_LW) || (op_i == OP_SW) || (op_i == OP_R) ||
                    (op_i == OP_I) || (op_i == OP_BEQ) || (op_i == OP_JAL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:               state_d = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:              state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      default:                state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update    = 1'b0;
    branch       = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    alu_op       = ALUOP_ADD;
    adr_src_o    = 1'b0;
    result_src_o = RES_ALUOUT;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_B;
    illegal_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write     = 1'b1;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALURESULT;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        illegal_o   = !op_legal;
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_A;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEMREAD: adr_src_o = 1'b1;
      S_MEMWRITE: begin
        adr_src_o = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        result_src_o = RES_DATA;
        reg_write    = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_o = SRCA_A;
        alu_op      = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a_o = SRCA_A;
        alu_src_b_o = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a_o = SRCA_A;
        alu_op      = ALUOP_SUB;
        branch      = 1'b1;
      end
      S_JAL: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_update   = 1'b1;
      end
      default: ;
    endcase
  end

  module_alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3_i),
    .op5_i         (op_i[5]),
    .funct7b5_i    (funct7b5_i),
    .alu_control_o (alu_control_o)
  );

  // Strobes are gated by reset so nothing is written while the core is held.
  assign pc_write_o  = rst_ni & (pc_update | (branch & zero_i));
  assign mem_write_o = rst_ni & mem_write;
  assign ir_write_o  = rst_ni & ir_write;
  assign reg_write_o = rst_ni & reg_write;
  assign imm_src_o   = imm_src_f(op_i);
  assign state_o     = state_q;

endmodule

// File: doc/module_mc_controller.md
# module_mc_controller

Multicycle control unit for the RV32I-subset processor core. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback cycles, and an ALU decoder drives the datapath muxes and write strobes. It sits directly upstream of the register file: its `reg_write_o` drives the register file write enable, and its mux selects choose the write-data source. Supported instructions are lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq and jal.

## Interface

No parameters.

- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `op_i` in 7: opcode from the instruction register.
- `funct3_i` in 3: instruction funct3.
- `funct7b5_i` in 1: instruction bit 30.
- `zero_i` in 1: ALU zero flag.
- `pc_write_o` out 1: PC register enable.
- `adr_src_o` out 1: memory address select; 0 = PC, 1 = Result.
- `mem_write_o` out 1: data memory write enable.
- `ir_write_o` out 1: instruction register and OldPC enable.
- `reg_write_o` out 1: register file write enable.
- `result_src_o` out 2: Result select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a_o` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = A.
- `alu_src_b_o` out 2: ALU B select; 00 = B, 01 = ImmExt, 10 = constant 4.
- `alu_control_o` out 3: ALU operation; 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `imm_src_o` out 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
- `illegal_o` out 1: high in DECODE when the opcode is unsupported.
- `state_o` out 4: current state, for debug.

## Operation

- **Opcodes:** lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- **States and transitions:**
  - FETCH → DECODE.
  - DECODE → MEMADR for lw and sw.
  - DECODE → EXECR for R-type.
  - DECODE → EXECI for I-type.
  - DECODE → BEQ for beq.
  - DECODE → JAL for jal.
  - DECODE → FETCH for an unsupported opcode.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB.
  - EXECR and EXECI → ALUWB.
  - JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- **Per-state outputs:** any output not listed is 0. ALUOp is internal.
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, ALUOp=00, result_src=10, pc_update=1.
  - DECODE: alu_src_a=01, alu_src_b=01, ALUOp=00. This computes the branch target.
  - MEMADR: alu_src_a=10, alu_src_b=01, ALUOp=00.
  - MEMREAD: result_src=00, adr_src=1.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1.
  - MEMWB: result_src=01, reg_write=1.
  - EXECR: alu_src_a=10, alu_src_b=00, ALUOp=10.
  - EXECI: alu_src_a=10, alu_src_b=01, ALUOp=10.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, ALUOp=01, result_src=00, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, ALUOp=00, result_src=00, pc_update=1.
- **PC write:** `pc_write_o = pc_update | (branch & zero_i)`.
- **ALU decoder:**
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10, funct3 000: sub when `{op_i[5], funct7b5_i} == 2'b11`, otherwise add.
  - ALUOp 10, funct3 010 → slt; 110 → or; 111 → and; any other funct3 → add.
- **Immediate decoder:** combinational from `op_i`: lw/I → 00, sw → 01, beq → 10, jal → 11, others → 00.
- **Illegal opcode:** `illegal_o` is high for the single DECODE cycle. No strobe is asserted and the PC is not modified beyond the increment done in FETCH.

## Timing

- State register is updated on the clock rising edge. Outputs are combinational from state, `op_i`, `funct*` and `zero_i`, with no extra latency.
- **Cycles per instruction:** lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2.
- **Reset:** asserting `rst_ni` low forces state = FETCH immediately, asynchronously.
  - While reset is low, `pc_write_o`, `ir_write_o`, `mem_write_o` and `reg_write_o` are forced to 0.
  - While reset is low, the other outputs show their FETCH values and `state_o` = FETCH encoding (0).
  - The first rising edge after release is a real FETCH cycle.
  - Reset mid-instruction abandons the instruction; no partial writes occur after assertion.
- `zero_i` is sampled only in BEQ. The inputs are stable from the IR from DECODE onward.

## Structure

- **Package `pkg_mc_ctrl`:**
  - state enum, 4-bit: FETCH=0, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, ALUWB, EXECI, JAL, BEQ.
  - opcode localparams.
  - encodings for result_src, alu_src_a, alu_src_b, alu_control and imm_src.
- **Sub-module `module_alu_decoder`:** combinational, with inputs ALUOp, `funct3_i`, `op_i[5]`, `funct7b5_i` and output `alu_control_o`. It is instantiated once.

## Test plan

- **Reset:** `rst_ni`=0 mid-MEMWRITE → `state_o`=0 and `mem_write_o`=0 in the same cycle. After release, `ir_write_o`=1 and `pc_write_o`=1 on the first cycle.
- **add then sub:** R-type add (op 0110011, funct3 000, funct7b5 0) → states 0,1,6,7. `alu_control_o`=000 in EXECR; `reg_write_o`=1 only in ALUWB. The same with funct7b5=1 → `alu_control_o`=001.
- **lw:** op 0000011 → 5 cycles: FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `adr_src_o`=1 in MEMREAD; `result_src_o`=01 with `reg_write_o`=1 in MEMWB. sw → `mem_write_o`=1 for exactly one cycle and `reg_write_o` never high.
- **beq:** with `zero_i`=1 → `pc_write_o`=1 in BEQ; with `zero_i`=0 → 0. The instruction takes 3 cycles and `imm_src_o`=10.
- **jal and addi:** jal → `pc_write_o`=1 and `alu_src_a_o`=01 in JAL, then ALUWB writes. addi with funct3 000 → add; slti (funct3 010) → 101, with no sub despite funct7b5=1.
- **Illegal:** op 1111111 → `illegal_o`=1 for one cycle in DECODE, then FETCH. No `reg_write_o` or `mem_write_o` is asserted.
